alu_result_stage: RTL and testbench

//  Execute/writeback pipeline register directly downstream of the 32-bit ALU. Captures

---
 rtl/alu_result_stage_pkg.sv | 19 +
 rtl/alu_result_fifo2.sv | 49 ++++
 rtl/alu_result_stage.sv | 65 ++++++
 tb/tb_alu_result_stage.sv | 126 ++++++++++++
 4 files changed

// File: rtl/alu_result_stage_pkg.sv
// alu_result_stage_pkg: shared widths, kind/opcode encodings, rstatus codes and entry record
package alu_result_stage_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] RSTATUS = 5'd30;
  typedef enum logic [1:0] {KIND_REG = 2'd0, KIND_BNE = 2'd1, KIND_BLT = 2'd2, KIND_NOWB = 2'd3} kind_t;
  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [DATA_W-1:0] CODE_ADD_OVF = 32'd1;
  localparam logic [DATA_W-1:0] CODE_SUB_OVF = 32'd3;
  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] data;
    logic              taken;
  } entry_t;
endpackage

// File: rtl/alu_result_fifo2.sv
// alu_result_fifo2: generic 2-entry valid/ready buffer, in_ready depends only on occupancy
module alu_result_fifo2 #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;
  logic [1:0]   state;
  logic [W-1:0] head, tail;
  logic         push, pop;
  assign in_ready  = state != FULL;
  assign out_valid = state != EMPTY;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? head : '0;
  // occupancy FSM with head/tail storage; flush empties and drops the incoming beat
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else if (state == EMPTY && push) begin
      head  <= in_data;
      state <= ONE;
    end else if (state == ONE && push && pop) begin
      head  <= in_data;
    end else if (state == ONE && push) begin
      tail  <= in_data;
      state <= FULL;
    end else if (state == ONE && pop) begin
      state <= EMPTY;
    end else if (state == FULL && pop) begin
      head  <= tail;
      state <= ONE;
    end
  end
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: ALU result pipeline register with r30 overflow rewrite and branch resolve; ALU_RESULT_STATS_EN adds counters
module alu_result_stage
  import alu_result_stage_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        alu_opcode,
  input  logic [1:0]        in_kind,
  input  logic [REG_AW-1:0] in_dest,
  input  logic [DATA_W-1:0] data_result,
  input  logic              isNotEqual,
  input  logic              isLessThan,
  input  logic              overflow,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_we,
  output logic [REG_AW-1:0] out_dest,
  output logic [DATA_W-1:0] out_data,
  output logic              out_taken
`ifdef ALU_RESULT_STATS_EN
  ,
  output logic [15:0]       stat_ovf_cnt,
  output logic [15:0]       stat_taken_cnt
`endif
);
  entry_t ent, head_e;
  logic   is_wr, ovf_rw, push;
  assign push = in_valid && in_ready && !flush;
  // entry formation: overflow on add/sub register writes is redirected to rstatus
  always_comb begin
    is_wr     = in_kind == KIND_REG;
    ovf_rw    = is_wr && overflow && (alu_opcode == OP_ADD || alu_opcode == OP_SUB);
    ent.we    = is_wr;
    ent.dest  = ovf_rw ? RSTATUS : in_dest;
    ent.data  = ovf_rw ? (alu_opcode == OP_SUB ? CODE_SUB_OVF : CODE_ADD_OVF) : data_result;
    ent.taken = in_kind == KIND_BNE ? isNotEqual : in_kind == KIND_BLT ? isLessThan : 1'b0;
  end
  alu_result_fifo2 #(.W($bits(entry_t))) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (ent),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (head_e)
  );
  assign {out_we, out_dest, out_data, out_taken} = head_e;
`ifdef ALU_RESULT_STATS_EN
  // saturating counts of pushed overflow rewrites and pushed taken branches
  always_ff @(posedge clock) begin
    if (!reset) begin
      stat_ovf_cnt   <= '0;
      stat_taken_cnt <= '0;
    end else begin
      if (push && ovf_rw && stat_ovf_cnt != 16'hFFFF) stat_ovf_cnt <= stat_ovf_cnt + 16'd1;
      if (push && ent.taken && stat_taken_cnt != 16'hFFFF) stat_taken_cnt <= stat_taken_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed plus random stimulus checked against a queue model of the stage
module tb_alu_result_stage;
  logic        clock = 0, reset = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [4:0]  alu_opcode = 0, in_dest = 0;
  logic [1:0]  in_kind = 0;
  logic [31:0] data_result = 0;
  logic        isNotEqual = 0, isLessThan = 0, overflow = 0;
  logic        in_ready, out_valid, out_we, out_taken;
  logic [4:0]  out_dest;
  logic [31:0] out_data;
`ifdef ALU_RESULT_STATS_EN
  logic [15:0] stat_ovf_cnt, stat_taken_cnt;
`endif
  int total = 0, bad = 0;
  logic [38:0] q[$];
  int m_ovf = 0, m_taken = 0;

  alu_result_stage dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_opcode(alu_opcode), .in_kind(in_kind), .in_dest(in_dest), .data_result(data_result),
    .isNotEqual(isNotEqual), .isLessThan(isLessThan), .overflow(overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_we(out_we), .out_dest(out_dest),
    .out_data(out_data), .out_taken(out_taken)
`ifdef ALU_RESULT_STATS_EN
    , .stat_ovf_cnt(stat_ovf_cnt), .stat_taken_cnt(stat_taken_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check();
    logic [38:0] h;
    h = q.size() > 0 ? q[0] : 39'd0;
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("out_we", 32'(out_we), 32'(h[38]));
    chk("out_dest", 32'(out_dest), 32'(h[37:33]));
    chk("out_data", out_data, h[32:1]);
    chk("out_taken", 32'(out_taken), 32'(h[0]));
`ifdef ALU_RESULT_STATS_EN
    chk("stat_ovf", 32'(stat_ovf_cnt), 32'(m_ovf));
    chk("stat_taken", 32'(stat_taken_cnt), 32'(m_taken));
`endif
  endtask

  // one cycle: apply inputs, advance model across the coming edge, then check after it
  task automatic cyc(input logic rst_n, input logic fl, input logic v, input logic [1:0] k,
                     input logic [4:0] op, input logic [4:0] d, input logic [31:0] r,
                     input logic ne, input logic lt, input logic ov, input logic ordy);
    logic we, tk, rw;
    logic [4:0] ed;
    logic [31:0] edat;
    bit pop, push;
    reset = rst_n; flush = fl; in_valid = v; in_kind = k; alu_opcode = op; in_dest = d;
    data_result = r; isNotEqual = ne; isLessThan = lt; overflow = ov; out_ready = ordy;
    we = k == 2'd0;
    rw = we && ov && (op == 5'd0 || op == 5'd1);
    ed = rw ? 5'd30 : d;
    edat = rw ? (op == 5'd1 ? 32'd3 : 32'd1) : r;
    tk = (k == 2'd1) ? ne : (k == 2'd2) ? lt : 1'b0;
    if (!rst_n) begin
      q.delete(); m_ovf = 0; m_taken = 0;
    end else begin
      pop = q.size() > 0 && ordy;
      push = v && q.size() < 2 && !fl;
      if (push && rw && m_ovf < 65535) m_ovf++;
      if (push && tk && m_taken < 65535) m_taken++;
      if (fl) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back({we, ed, edat, tk});
      end
    end
    @(negedge clock);
    check();
  endtask

  initial begin
    @(negedge clock);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // add overflow -> rstatus code 1
    cyc(1, 0, 1, 0, 5'd0, 5'd5, 32'h80000000, 0, 0, 1, 1);
    // sub overflow -> code 3, then and-op overflow keeps dest/data
    cyc(1, 0, 1, 0, 5'd1, 5'd6, 32'h7FFFFFFF, 0, 0, 1, 1);
    cyc(1, 0, 1, 0, 5'd2, 5'd7, 32'h12345678, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // backpressure: three beats with out_ready low
    cyc(1, 0, 1, 0, 5'd0, 5'd1, 32'hA1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 5'd0, 5'd2, 32'hA2, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 5'd0, 5'd3, 32'hA3, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 5'd0, 5'd3, 32'hA3, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // branches: bne taken, blt not taken
    cyc(1, 0, 1, 2'd1, 5'd1, 5'd9, 32'h55, 1, 1, 0, 0);
    cyc(1, 0, 1, 2'd2, 5'd1, 5'd9, 32'h66, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // fill, then flush with an incoming beat
    cyc(1, 0, 1, 0, 5'd0, 5'd4, 32'hB1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 5'd0, 5'd4, 32'hB2, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 5'd0, 5'd4, 32'hB3, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // fill, then reset mid-stream
    cyc(1, 0, 1, 2'd1, 5'd0, 5'd4, 32'hC1, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 5'd0, 5'd4, 32'hC2, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 5'd0, 5'd4, 32'hC3, 0, 0, 1, 1);
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(59) != 0), ($urandom_range(24) == 0), 1'($urandom),
          2'($urandom), 5'($urandom_range(4)), 5'($urandom), $urandom,
          1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(2) != 0));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
